// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock in circular, linear or hyperbolic mode.
// Optional output gain compensation is enabled by defining CORDIC_GAIN_COMP_EN.
module cordic_iter_engine #(
   parameter int unsigned      WIDTH  = 16,
   parameter int unsigned      ITER   = 16,
   parameter logic [WIDTH-1:0] GAIN_Q = 16'h26DD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       coordinate_system,
   input  logic             vectoring,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] y_in,
   input  logic [WIDTH-1:0] z_in,
   output logic [5:0]       iter_idx,
   input  logic [WIDTH-1:0] angle_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] x_out,
   output logic [WIDTH-1:0] y_out,
   output logic [WIDTH-1:0] z_out
);

   if (ITER > 48) begin : g_iter_chk
      $error("cordic_iter_engine: ITER=%0d exceeds the maximum of 48", ITER);
   end
   if (GAIN_Q[WIDTH-1]) begin : g_gain_chk
      $error("cordic_iter_engine: GAIN_Q must be a positive constant");
   end

   typedef enum logic [1:0] {StIdle, StRun, StGain, StDone} state_e;

   localparam logic [WIDTH-1:0] LinOne = WIDTH'(1) << (WIDTH - 2);
   localparam logic [5:0]       LastIdx = 6'(ITER - 1);

   state_e                  state_q, state_d;
   logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic [1:0]              mode_q, mode_d;
   logic                    vec_q, vec_d;
   logic [5:0]              idx_q, idx_d;
   logic                    rep_q, rep_d;
   logic                    out_valid_q, out_valid_d;

   logic                    is_circ, is_lin, is_hyp, d_pos, rep_pt;
   logic signed [WIDTH-1:0] x_sh, y_sh, ang;

   always_comb begin
      is_circ = (mode_q == 2'b00);
      is_lin  = (mode_q == 2'b01);
      is_hyp  = mode_q[1];
      // Rotation steers z toward zero, vectoring steers y toward zero.
      d_pos   = vec_q ? y_q[WIDTH-1] : ~z_q[WIDTH-1];
      x_sh    = x_q >>> idx_q;
      y_sh    = y_q >>> idx_q;
      ang     = is_lin ? $signed(LinOne >> idx_q) : $signed(angle_in);
      // Hyperbolic convergence needs indices 4, 13 and 40 executed twice.
      rep_pt  = is_hyp && !rep_q && (idx_q == 6'd4 || idx_q == 6'd13 || idx_q == 6'd40);
   end

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      mode_d      = mode_q;
      vec_d       = vec_q;
      idx_d       = idx_q;
      rep_d       = rep_q;
      out_valid_d = out_valid_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               x_d     = $signed(x_in);
               y_d     = $signed(y_in);
               z_d     = $signed(z_in);
               mode_d  = coordinate_system;
               vec_d   = vectoring;
               idx_d   = coordinate_system[1] ? 6'd1 : 6'd0;
               rep_d   = 1'b0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (is_circ) begin
               x_d = d_pos ? x_q - y_sh : x_q + y_sh;
            end else if (is_hyp) begin
               x_d = d_pos ? x_q + y_sh : x_q - y_sh;
            end
            y_d = d_pos ? y_q + x_sh : y_q - x_sh;
            z_d = d_pos ? z_q - ang : z_q + ang;
            if (rep_pt) begin
               rep_d = 1'b1;
            end else begin
               rep_d = 1'b0;
               if (idx_q >= LastIdx) begin
                  idx_d = 6'd0;
`ifdef CORDIC_GAIN_COMP_EN
                  state_d = StGain;
`else
                  state_d = StDone;
`endif
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
         end
`ifdef CORDIC_GAIN_COMP_EN
         StGain: begin
            if (is_circ) begin
               x_d = WIDTH'(($signed({{WIDTH{x_q[WIDTH-1]}}, x_q}) *
                             $signed({{WIDTH{1'b0}}, GAIN_Q})) >>> (WIDTH - 2));
               y_d = WIDTH'(($signed({{WIDTH{y_q[WIDTH-1]}}, y_q}) *
                             $signed({{WIDTH{1'b0}}, GAIN_Q})) >>> (WIDTH - 2));
            end
            state_d = StDone;
         end
`endif
         StDone: begin
            // First DONE cycle registers out_valid; the handshake is taken once it is visible.
            out_valid_d = 1'b1;
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         mode_q      <= 2'b00;
         vec_q       <= 1'b0;
         idx_q       <= 6'd0;
         rep_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         mode_q      <= mode_d;
         vec_q       <= vec_d;
         idx_q       <= idx_d;
         rep_q       <= rep_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = out_valid_q;
   assign iter_idx  = (state_q == StRun) ? idx_q : 6'd0;
   assign x_out     = x_q;
   assign y_out     = y_q;
   assign z_out     = z_q;

endmodule
